// File: rtl/cmos_capture_ctrl.sv
// Frame-level capture sequencer: skips settling frames, gates capture on vsync,
// clips lines/frames to the active window and flags short or malformed frames.
//   state   | meaning
//   IDLE    | capture disabled, waiting for capture_en
//   SKIP    | discarding camera settling frames (counts vsync pulses)
//   WAIT_VS | armed, waiting for the next frame start
//   ACTIVE  | capturing the current frame
module cmos_capture_ctrl #(
    parameter int H_ACTIVE    = 1024,
    parameter int V_ACTIVE    = 768,
    parameter int SKIP_FRAMES = 10,
    parameter int DW          = 16
) (
    input  logic                          cmos_pclk,
    input  logic                          rst_n,
    input  logic                          capture_en,
    input  logic                          vsync_pulse,
    input  logic                          href_in,
    input  logic [DW-1:0]                 data_in,
    output logic                          wr_en,
    output logic [DW-1:0]                 wr_data,
    output logic                          frame_start,
    output logic                          frame_done,
    output logic                          frame_err,
    output logic                          busy,
    output logic [$clog2(V_ACTIVE+1)-1:0] line_cnt,
    output logic [7:0]                    frame_cnt
);

    localparam int PW = $clog2(H_ACTIVE + 2);
    localparam int LW = $clog2(V_ACTIVE + 1);
    localparam int SW = $clog2(SKIP_FRAMES + 2);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SKIP    = 2'd1;
    localparam logic [1:0] WAIT_VS = 2'd2;
    localparam logic [1:0] ACTIVE  = 2'd3;

    logic [1:0]    state;
    logic [SW-1:0] skip_cnt;
    logic          skip_done;
    logic [PW-1:0] pix_cnt;
    logic          line_err;
    logic          href_d;

    logic          line_end;
    logic          line_bad;
    logic [LW-1:0] line_nxt;
    logic          last_line;

    assign line_end  = href_d & ~href_in;
    assign line_bad  = line_err | (pix_cnt != PW'(H_ACTIVE));
    assign line_nxt  = line_cnt + LW'(1);
    assign last_line = line_end && (line_nxt == LW'(V_ACTIVE));
    assign busy      = (state == ACTIVE);

    always_ff @(posedge cmos_pclk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            skip_cnt    <= '0;
            skip_done   <= 1'b0;
            pix_cnt     <= '0;
            line_err    <= 1'b0;
            href_d      <= 1'b0;
            wr_en       <= 1'b0;
            wr_data     <= '0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
            line_cnt    <= '0;
            frame_cnt   <= '0;
        end else begin
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
            wr_en       <= 1'b0;
            href_d      <= href_in;
            case (state)
                IDLE: begin
                    if (capture_en)
                        state <= (!skip_done && SKIP_FRAMES > 0) ? SKIP : WAIT_VS;
                end
                SKIP: begin
                    if (vsync_pulse) begin
                        skip_cnt <= skip_cnt + SW'(1);
                        if (skip_cnt + SW'(1) == SW'(SKIP_FRAMES)) begin
                            skip_done <= 1'b1;
                            state     <= WAIT_VS;
                        end
                    end
                end
                WAIT_VS: begin
                    if (!capture_en) begin
                        state <= IDLE;
                    end else if (vsync_pulse) begin
                        state       <= ACTIVE;
                        frame_start <= 1'b1;
                        pix_cnt     <= '0;
                        line_cnt    <= '0;
                        line_err    <= 1'b0;
                    end
                end
                ACTIVE: begin
                    wr_en   <= href_in && (pix_cnt < PW'(H_ACTIVE));
                    wr_data <= data_in;
                    // A completing line end wins over a coincident vsync pulse.
                    if (last_line) begin
                        line_cnt <= line_nxt;
                        pix_cnt  <= '0;
                        line_err <= line_bad;
                        if (line_bad) begin
                            frame_err <= 1'b1;
                        end else begin
                            frame_done <= 1'b1;
                            frame_cnt  <= frame_cnt + 8'd1;
                        end
                        state <= capture_en ? WAIT_VS : IDLE;
                    end else if (vsync_pulse) begin
                        frame_err <= 1'b1;
                        if (capture_en) begin
                            frame_start <= 1'b1;
                            pix_cnt     <= '0;
                            line_cnt    <= '0;
                            line_err    <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (line_end) begin
                        line_cnt <= line_nxt;
                        pix_cnt  <= '0;
                        line_err <= line_bad;
                    end else if (href_in && pix_cnt != PW'(H_ACTIVE + 1)) begin
                        pix_cnt <= pix_cnt + PW'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmos_capture_ctrl.sv
// Scoreboard bench for cmos_capture_ctrl: stimulus pushes expected pixels and
// frame events, a negedge monitor pops and compares them as the DUT emits.
module tb_cmos_capture_ctrl;

    localparam int H  = 8;
    localparam int V  = 4;
    localparam int SK = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        capture_en;
    logic        vsync_pulse;
    logic        href_in;
    logic [15:0] data_in;
    logic        wr_en;
    logic [15:0] wr_data;
    logic        frame_start;
    logic        frame_done;
    logic        frame_err;
    logic        busy;
    logic [2:0]  line_cnt;
    logic [7:0]  frame_cnt;

    always #5 clk = ~clk;

    cmos_capture_ctrl #(
        .H_ACTIVE(H), .V_ACTIVE(V), .SKIP_FRAMES(SK), .DW(16)
    ) dut (
        .cmos_pclk(clk), .rst_n(rst_n), .capture_en(capture_en),
        .vsync_pulse(vsync_pulse), .href_in(href_in), .data_in(data_in),
        .wr_en(wr_en), .wr_data(wr_data), .frame_start(frame_start),
        .frame_done(frame_done), .frame_err(frame_err), .busy(busy),
        .line_cnt(line_cnt), .frame_cnt(frame_cnt)
    );

    // kind = {start, done, err}
    typedef struct packed {
        logic [2:0] kind;
        logic [7:0] fc;
        logic [2:0] lc;
    } ev_t;

    localparam logic [2:0] K_START = 3'b100;
    localparam logic [2:0] K_DONE  = 3'b010;
    localparam logic [2:0] K_ERR   = 3'b001;

    ev_t         ev_q[$];
    logic [15:0] px_q[$];
    int          checks = 0;
    int          errors = 0;
    int          fc     = 0;

    function automatic void push_ev(input logic [2:0] k, input int f, input int l);
        ev_t e;
        e.kind = k;
        e.fc   = 8'(f);
        e.lc   = 3'(l);
        ev_q.push_back(e);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [15:0] ep;
        ev_t         ee;
        ev_t         ae;
        if (rst_n === 1'b1) begin
            if (wr_en === 1'b1) begin
                checks++;
                if (px_q.size() == 0) begin
                    errors++;
                    $display("FAIL wr_en_unexpected: wr_data=%h with no pixel expected", wr_data);
                end else begin
                    ep = px_q.pop_front();
                    if (wr_data !== ep) begin
                        errors++;
                        $display("FAIL wr_data: got %h expected %h", wr_data, ep);
                    end
                end
            end
            if ((frame_start | frame_done | frame_err) === 1'b1) begin
                checks++;
                ae.kind = {frame_start, frame_done, frame_err};
                ae.fc   = frame_cnt;
                ae.lc   = line_cnt;
                if (ev_q.size() == 0) begin
                    errors++;
                    $display("FAIL event_unexpected: kind=%b fc=%0d lc=%0d", ae.kind, ae.fc, ae.lc);
                end else begin
                    ee = ev_q.pop_front();
                    if (ae !== ee) begin
                        errors++;
                        $display("FAIL frame_event: got kind=%b fc=%0d lc=%0d expected kind=%b fc=%0d lc=%0d",
                                 ae.kind, ae.fc, ae.lc, ee.kind, ee.fc, ee.lc);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic vs(input bit exp_start);
        vsync_pulse = 1'b1;
        tick(1);
        vsync_pulse = 1'b0;
        chk("frame_start_after_vsync", int'(frame_start), int'(exp_start));
    endtask

    task automatic do_line(input int n, input int base, input bit cap, input int drop_at);
        for (int i = 0; i < n; i++) begin
            if (i == drop_at) capture_en = 1'b0;
            href_in = 1'b1;
            data_in = 16'(base + i);
            if (cap && i < H) px_q.push_back(16'(base + i));
            tick(1);
        end
        href_in = 1'b0;
        tick(2);
    endtask

    task automatic frame(input bit cap);
        for (int l = 0; l < V; l++) do_line(H, l * H, cap, -1);
    endtask

    initial begin
        rst_n       = 1'b0;
        capture_en  = 1'b0;
        vsync_pulse = 1'b0;
        href_in     = 1'b0;
        data_in     = '0;
        tick(2);
        chk("reset_pulses", int'({wr_en, frame_start, frame_done, frame_err, busy}), 0);
        chk("reset_line_cnt", int'(line_cnt), 0);
        chk("reset_frame_cnt", int'(frame_cnt), 0);
        chk("reset_wr_data", int'(wr_data), 0);
        rst_n = 1'b1;
        tick(1);

        // 1: two settling frames skipped, third captured
        capture_en = 1'b1;
        tick(2);
        vs(1'b0); frame(1'b0);
        vs(1'b0); frame(1'b0);
        chk("busy_after_skip", int'(busy), 0);
        push_ev(K_START, 0, 0);
        push_ev(K_DONE, 1, V);
        fc = 1;
        vs(1'b1);
        chk("busy_in_frame", int'(busy), 1);
        frame(1'b1);
        chk("frame_cnt_first", int'(frame_cnt), 1);
        chk("line_cnt_hold", int'(line_cnt), V);
        chk("busy_after_frame", int'(busy), 0);

        // 2: overlong line clipped, frame flagged
        push_ev(K_START, fc, 0);
        push_ev(K_ERR, fc, V);
        vs(1'b1);
        do_line(8, 0, 1'b1, -1);
        do_line(10, 8, 1'b1, -1);
        do_line(8, 18, 1'b1, -1);
        do_line(8, 26, 1'b1, -1);
        chk("frame_cnt_after_err", int'(frame_cnt), 1);

        // 3: short frame restart
        push_ev(K_START, fc, 0);
        vs(1'b1);
        do_line(8, 0, 1'b1, -1);
        do_line(8, 8, 1'b1, -1);
        push_ev(K_START | K_ERR, fc, 0);
        vs(1'b1);
        chk("busy_after_restart", int'(busy), 1);
        chk("line_cnt_after_restart", int'(line_cnt), 0);
        push_ev(K_DONE, fc + 1, V);
        fc = fc + 1;
        frame(1'b1);

        // 4: enable dropped mid-frame, then re-enabled without re-skip
        push_ev(K_START, fc, 0);
        push_ev(K_DONE, fc + 1, V);
        fc = fc + 1;
        vs(1'b1);
        do_line(8, 0, 1'b1, -1);
        do_line(8, 8, 1'b1, 3);
        do_line(8, 16, 1'b1, -1);
        do_line(8, 24, 1'b1, -1);
        chk("busy_after_drop", int'(busy), 0);
        capture_en = 1'b1;
        tick(2);
        push_ev(K_START, fc, 0);
        push_ev(K_DONE, fc + 1, V);
        fc = fc + 1;
        vs(1'b1);
        frame(1'b1);
        chk("frame_cnt_reenable", int'(frame_cnt), 4);

        // 5: run frames until frame_cnt wraps to 0
        while (fc != 0) begin
            push_ev(K_START, fc, 0);
            fc = (fc + 1) % 256;
            push_ev(K_DONE, fc, V);
            vs(1'b1);
            frame(1'b1);
        end
        chk("frame_cnt_wrap", int'(frame_cnt), 0);

        // 6: reset mid-line, skip repeats afterwards
        push_ev(K_START, fc, 0);
        vs(1'b1);
        do_line(8, 0, 1'b1, -1);
        do_line(8, 8, 1'b1, -1);
        for (int i = 0; i < 4; i++) begin
            href_in = 1'b1;
            data_in = 16'(16 + i);
            px_q.push_back(16'(16 + i));
            tick(1);
        end
        #5;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_wr_en", int'(wr_en), 0);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_line_cnt", int'(line_cnt), 0);
        href_in = 1'b0;
        fc = 0;
        tick(2);
        chk("px_q_drained_at_reset", px_q.size(), 0);
        rst_n = 1'b1;
        tick(2);
        vs(1'b0); frame(1'b0);
        vs(1'b0); frame(1'b0);
        push_ev(K_START, 0, 0);
        push_ev(K_DONE, 1, V);
        fc = 1;
        vs(1'b1);
        frame(1'b1);
        chk("frame_cnt_after_reset", int'(frame_cnt), 1);

        tick(2);
        chk("px_q_empty", px_q.size(), 0);
        chk("ev_q_empty", ev_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
